// File: rtl/program_loader_if.sv
// Byte-stream and processor-side signals of the program loader, bundled
// so the loader and whatever hosts it share one declaration.
interface program_loader_if;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] new_instruction;
  logic        word_valid;
  logic        add_into;
  logic        start_signal;
  logic        end_signal;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;
  logic [31:0] run_cycles;

  // Host side: feeds the byte stream, reports processor completion.
  modport master (
    output rx_byte, rx_valid, end_signal,
    input  rx_ready, new_instruction, word_valid, add_into, start_signal,
           busy, done, error, err_code, run_cycles
  );

  // Loader side.
  modport slave (
    input  rx_byte, rx_valid, end_signal,
    output rx_ready, new_instruction, word_valid, add_into, start_signal,
           busy, done, error, err_code, run_cycles
  );
endinterface

// File: rtl/program_loader.sv
// Program loader: parses a 4-byte header (instruction and data word
// counts), assembles little-endian 32-bit words from a byte stream and
// strobes them to the processor, then starts it and times the run.
module program_loader #(
  parameter int MAX_INSTR = 1024,
  parameter int MAX_DATA  = 1024,
  parameter int TIMEOUT   = 100000
) (
  input logic             clk,
  input logic             reset,
  program_loader_if.slave bus
);

  localparam logic [2:0] HDR   = 3'd0;
  localparam logic [2:0] INSTR = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] START = 3'd3;
  localparam logic [2:0] RUN   = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;
  localparam logic [2:0] ERR   = 3'd6;

  localparam logic [31:0] MAX_I     = 32'(MAX_INSTR);
  localparam logic [31:0] MAX_D     = 32'(MAX_DATA);
  localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT);

  logic [2:0]  state;
  logic [1:0]  byte_cnt;     // byte position within header or word
  logic [15:0] word_cnt;     // words strobed in the current section
  logic [15:0] ni;
  logic [15:0] nd;
  logic [23:0] word_buf;     // first three bytes of the word in flight
  logic [31:0] new_instruction;
  logic        word_valid;
  logic        add_into;
  logic [1:0]  err_code;
  logic [31:0] run_cycles;

  logic        loading;
  logic        rx_ready;
  logic        accept;
  logic        word_done;
  logic [15:0] hdr_nd;

  // Bytes are taken only while loading, and never in a strobe cycle so the
  // section bookkeeping for the strobed word settles first.
  assign loading   = (state == HDR) || (state == INSTR) || (state == DATA);
  assign rx_ready  = loading && !word_valid;
  assign accept    = bus.rx_valid && rx_ready;
  assign word_done = accept && (state != HDR) && (byte_cnt == 2'd3);
  assign hdr_nd    = {bus.rx_byte, nd[7:0]};

  // Main sequencer: header parse, word assembly, section changes, run timing.
  // NOTE: every register here uses <= so all branches see pre-edge values;
  // a blocking assignment would let later statements read half-updated state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= HDR;
      byte_cnt        <= '0;
      word_cnt        <= '0;
      ni              <= '0;
      nd              <= '0;
      word_buf        <= '0;
      new_instruction <= '0;
      word_valid      <= 1'b0;
      add_into        <= 1'b0;
      err_code        <= '0;
      run_cycles      <= '0;
    end else begin
      word_valid <= 1'b0;
      if (accept) byte_cnt <= byte_cnt + 2'd1;

      if (accept && state != HDR) begin
        unique case (byte_cnt)
          2'd0:    word_buf[7:0]   <= bus.rx_byte;
          2'd1:    word_buf[15:8]  <= bus.rx_byte;
          2'd2:    word_buf[23:16] <= bus.rx_byte;
          default: begin
            new_instruction <= {bus.rx_byte, word_buf};
            word_valid      <= 1'b1;
          end
        endcase
      end

      case (state)
        HDR: if (accept) begin
          unique case (byte_cnt)
            2'd0:    ni[7:0]  <= bus.rx_byte;
            2'd1:    ni[15:8] <= bus.rx_byte;
            2'd2:    nd[7:0]  <= bus.rx_byte;
            default: begin
              nd[15:8] <= bus.rx_byte;
              if (32'(ni) > MAX_I || 32'(hdr_nd) > MAX_D) begin
                state    <= ERR;
                err_code <= 2'd1;
              end else if (ni != 16'd0) begin
                state <= INSTR;
              end else begin
                add_into <= 1'b1;
                state    <= (hdr_nd != 16'd0) ? DATA : START;
              end
            end
          endcase
        end
        // The processor writes the last instruction word on the edge that
        // ends its strobe; add_into flips on that same edge.
        INSTR: begin
          if (word_valid && word_cnt == ni) begin
            add_into <= 1'b1;
            word_cnt <= '0;
            state    <= (nd != 16'd0) ? DATA : START;
          end else if (word_done) begin
            word_cnt <= word_cnt + 16'd1;
          end
        end
        DATA: begin
          if (word_valid && word_cnt == nd) state <= START;
          else if (word_done) word_cnt <= word_cnt + 16'd1;
        end
        START: begin
          run_cycles <= '0;
          state      <= RUN;
        end
        RUN: begin
          if (bus.end_signal) begin
            state <= DONE;
          end else begin
            if (run_cycles != '1) run_cycles <= run_cycles + 32'd1;
            if (TIMEOUT != 0 && run_cycles + 32'd1 == TIMEOUT_W) begin
              state    <= ERR;
              err_code <= 2'd2;
            end
          end
        end
        default: ;  // DONE and ERR hold until reset
      endcase
    end
  end

  assign bus.rx_ready        = rx_ready;
  assign bus.new_instruction = new_instruction;
  assign bus.word_valid      = word_valid;
  assign bus.add_into        = add_into;
  assign bus.start_signal    = (state == START) || (state == RUN);
  assign bus.busy            = (state != DONE) && (state != ERR);
  assign bus.done            = (state == DONE);
  assign bus.error           = (state == ERR);
  assign bus.err_code        = err_code;
  assign bus.run_cycles      = run_cycles;

endmodule
